// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS multiply/divide unit: op encoding, sequencer states, iteration count.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } muldiv_state_t;

    localparam int MULDIV_CYCLES = 32;

    function automatic logic op_is_div(input muldiv_op_t o);
        return (o == DIV) || (o == DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t o);
        return (o == MULT) || (o == DIV);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One combinational iteration of the muldiv datapath on {acc, q}:
// shift-add (multiply, LSB first) or restoring subtract (divide, MSB first).
module mips_cpu_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, opnd};
        rem      = {acc, q[WIDTH-1]};
        diff     = rem - {1'b0, opnd};
        acc_next = acc;
        q_next   = q;
        if (is_div) begin
            // diff[WIDTH] is the borrow: set means the partial remainder is below the divisor
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (q[0]) begin
                {acc_next, q_next} = {sum, q[WIDTH-1:1]};
            end else begin
                {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall generation.
// Build option: MULDIV_FAST_MULT_EN makes MULT/MULTU single-cycle via '*' (divides stay iterative).
//
// state | meaning
// IDLE  | accepts start or MTHI/MTLO writes
// RUN   | one datapath iteration per cycle until counter reaches 0
// FIX   | sign fixup, HI/LO written, done pulsed next cycle
module mips_cpu_muldiv_ctrl
    import mips_cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = MULDIV_CYCLES,
    parameter logic [DATA_WIDTH-1:0] DIV0_LO    = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  write_hi,
    input  logic                  write_lo,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  read_hilo,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done,
    output logic                  stall
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    muldiv_state_t state, state_next;
    muldiv_op_t    op_in;

    logic [CW-1:0]  cnt;
    logic [W-1:0]   acc, q, opnd;
    logic [W-1:0]   acc_step, q_step;
    logic [W-1:0]   mag_a, mag_b;
    logic           is_div, neg_lo, neg_hi, div0;
    logic           sgn_in, div_in;
    logic           fast_mult;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   hi_fix, lo_fix;

    assign op_in  = muldiv_op_t'(op);
    assign sgn_in = op_is_signed(op_in);
    assign div_in = op_is_div(op_in);
    assign mag_a  = (sgn_in && a[W-1]) ? -a : a;
    assign mag_b  = (sgn_in && b[W-1]) ? -b : b;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*W-1:0] fast_prod;
    assign fast_mult = !div_in;
    assign fast_prod = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
`else
    assign fast_mult = 1'b0;
`endif

    assign busy  = (state != IDLE);
    assign stall = busy & (read_hilo | start | write_hi | write_lo);

    mips_cpu_muldiv_step #(
        .WIDTH (W)
    ) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .q        (q),
        .opnd     (opnd),
        .acc_next (acc_step),
        .q_next   (q_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = fast_mult ? FIX : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Magnitudes were iterated; restore signs here. Divide-by-zero leaves |a| in acc,
    // so the remainder-sign fixup already reproduces a; only LO needs forcing.
    always_comb begin
        prod_fix = neg_lo ? -{acc, q} : {acc, q};
        hi_fix   = prod_fix[2*W-1:W];
        lo_fix   = prod_fix[W-1:0];
        if (is_div) begin
            hi_fix = neg_hi ? -acc : acc;
            lo_fix = div0 ? DIV0_LO : (neg_lo ? -q : q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= div_in;
                        div0   <= div_in && (b == '0);
                        neg_lo <= sgn_in && (a[W-1] ^ b[W-1]);
                        neg_hi <= sgn_in && a[W-1];
                        cnt    <= CW'(DATA_WIDTH - 1);
                        opnd   <= div_in ? mag_b : mag_a;
                        acc    <= '0;
                        q      <= div_in ? mag_a : mag_b;
`ifdef MULDIV_FAST_MULT_EN
                        if (fast_mult) begin
                            {acc, q} <= fast_prod;
                        end
`endif
                    end else begin
                        if (write_hi) hi <= wdata;
                        if (write_lo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    q   <= q_step;
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    hi   <= hi_fix;
                    lo   <= lo_fix;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
